// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sizes, FSM encoding and coefficient table for the serial FIR filter
package fir_pkg;

   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_FIR_DEPTH  = 32;
   localparam int DEF_ACC_WIDTH  = 2*DEF_DATA_WIDTH + $clog2(DEF_FIR_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RX   = 3'd1,
      ST_MAC  = 3'd2,
      ST_TX   = 3'd3,
      ST_ACK  = 3'd4
   } fir_state_t;

   // Triangular low-pass window: weights 1..16..1, DC gain 272*30000/2^23 (just under 1.0).
   localparam int COEF_STEP = 30000;

   function automatic logic [DEF_FIR_DEPTH*DEF_DATA_WIDTH-1:0] build_coefs();
      logic [DEF_FIR_DEPTH*DEF_DATA_WIDTH-1:0] flat;
      int weight;
      flat = '0;
      for (int k = 0; k < DEF_FIR_DEPTH; k++) begin
         weight = (k < DEF_FIR_DEPTH/2) ? (k + 1) : (DEF_FIR_DEPTH - k);
         flat[k*DEF_DATA_WIDTH +: DEF_DATA_WIDTH] = DEF_DATA_WIDTH'(weight * COEF_STEP);
      end
      return flat;
   endfunction

   // Tap k lives in bits [k*DATA_WIDTH +: DATA_WIDTH]; tap 0 multiplies the newest sample.
   localparam logic [DEF_FIR_DEPTH*DEF_DATA_WIDTH-1:0] DEF_COEF_FLAT = build_coefs();

endpackage

// File: rtl/fir_mac_core.sv
// rtl/fir_mac_core.sv - delay line, sequential multiply-accumulate and output saturation
module fir_mac_core import fir_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIR_DEPTH  = DEF_FIR_DEPTH,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(FIR_DEPTH),
   parameter logic [FIR_DEPTH*DATA_WIDTH-1:0] COEFS = DEF_COEF_FLAT
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_sample,
   input  logic                  i_run,
   output logic                  o_last,
   output logic [DATA_WIDTH-1:0] o_result
);

   localparam int TAP_W  = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1;
   localparam int PROD_W = 2*DATA_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [DATA_WIDTH-1:0] taps [FIR_DEPTH];
   logic        [TAP_W-1:0]      tap_cnt;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [ACC_WIDTH-1:0]  acc_next;
   logic signed [ACC_WIDTH-1:0]  acc_shift;
   logic signed [DATA_WIDTH-1:0] tap_sel;
   logic signed [DATA_WIDTH-1:0] coef_sel;
   logic signed [PROD_W-1:0]     prod;
   logic        [DATA_WIDTH-1:0] sat_word;

   assign o_last = i_run && (tap_cnt == TAP_W'(FIR_DEPTH-1));

   // Current tap product, next accumulator value and its rescaled, clamped form
   always_comb begin
      tap_sel   = taps[tap_cnt];
      coef_sel  = COEFS[tap_cnt*DATA_WIDTH +: DATA_WIDTH];
      prod      = tap_sel * coef_sel;
      acc_next  = acc + $signed({{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod});
      acc_shift = acc_next >>> (DATA_WIDTH-1);
      if (acc_shift > SAT_MAX) begin
         sat_word = SAT_MAX[DATA_WIDTH-1:0];
      end else if (acc_shift < SAT_MIN) begin
         sat_word = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         sat_word = acc_shift[DATA_WIDTH-1:0];
      end
   end

   // Delay line: a completed word enters at position 0 and the oldest sample falls off the end
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int k = 0; k < FIR_DEPTH; k++) begin
            taps[k] <= '0;
         end
      end else if (i_en && i_push) begin
         taps[0] <= i_sample;
         for (int k = 1; k < FIR_DEPTH; k++) begin
            taps[k] <= taps[k-1];
         end
      end
   end

   // Accumulator and tap index: cleared with each new sample, one product per MAC cycle
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         acc     <= '0;
         tap_cnt <= '0;
      end else if (i_en) begin
         if (i_push) begin
            acc     <= '0;
            tap_cnt <= '0;
         end else if (i_run) begin
            acc     <= acc_next;
            tap_cnt <= o_last ? '0 : tap_cnt + TAP_W'(1);
         end
      end
   end

   // Result register captures the final sum, so it stays stable through the whole TX phase
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_result <= '0;
      end else if (i_en && o_last) begin
         o_result <= sat_word;
      end
   end

endmodule

// File: rtl/fir_filter_top.sv
// rtl/fir_filter_top.sv - bit-serial FIR filter: deserializer, control FSM and serializer
module fir_filter_top import fir_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIR_DEPTH  = DEF_FIR_DEPTH,
   parameter logic [FIR_DEPTH*DATA_WIDTH-1:0] COEFS = DEF_COEF_FLAT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_din,
   input  logic i_din_valid,
   input  logic i_ready,
   output logic o_ready,
   output logic o_dout,
   output logic o_dout_valid
);

   localparam int ACC_W = 2*DATA_WIDTH + $clog2(FIR_DEPTH);
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH-1);

   fir_state_t            state;
   fir_state_t            state_next;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] rx_word;
   logic [DATA_WIDTH-1:0] rx_next;
   logic                  ack_flag;
   logic                  accept;
   logic                  word_done;
   logic                  mac_run;
   logic                  mac_last;
   logic [DATA_WIDTH-1:0] result;

   // LSB arrives first, so bits shift in from the top and bit 0 ends up at the bottom
   assign rx_next = {i_din, rx_word[DATA_WIDTH-1:1]};
   assign mac_run = (state == ST_MAC);

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= ST_IDLE;
      end else if (i_en) begin
         state <= state_next;
      end
   end

   // Next-state decode and handshake outputs
   always_comb begin
      state_next   = state;
      o_ready      = 1'b0;
      o_dout       = 1'b0;
      o_dout_valid = 1'b0;
      accept       = 1'b0;
      word_done    = 1'b0;
      case (state)
         ST_IDLE: begin
            o_ready = 1'b1;
            accept  = i_en && i_din_valid;
            if (accept) begin
               state_next = ST_RX;
            end
         end
         ST_RX: begin
            o_ready = 1'b1;
            accept  = i_en && i_din_valid;
            if (accept && (bit_cnt == LAST_BIT)) begin
               word_done  = 1'b1;
               state_next = ST_MAC;
            end
         end
         ST_MAC: begin
            if (i_en && mac_last) begin
               state_next = ST_TX;
            end
         end
         ST_TX: begin
            o_dout_valid = 1'b1;
            o_dout       = result[bit_cnt];
            if (i_en && (bit_cnt == LAST_BIT)) begin
               state_next = (ack_flag || i_ready) ? ST_IDLE : ST_ACK;
            end
         end
         ST_ACK: begin
            if (i_en && i_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Bit counter, input shift register and downstream acknowledge flag
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         bit_cnt  <= '0;
         rx_word  <= '0;
         ack_flag <= 1'b0;
      end else if (i_en) begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rx_word <= rx_next;
                  bit_cnt <= BIT_W'(1);
               end
            end
            ST_RX: begin
               if (accept) begin
                  rx_word <= rx_next;
                  bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
               end
            end
            ST_MAC: begin
               bit_cnt  <= '0;
               ack_flag <= 1'b0;
            end
            ST_TX: begin
               if (i_ready) begin
                  ack_flag <= 1'b1;
               end
               bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   fir_mac_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIR_DEPTH  (FIR_DEPTH),
      .ACC_WIDTH  (ACC_W),
      .COEFS      (COEFS)
   ) u_mac (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (i_en),
      .i_push   (word_done),
      .i_sample (rx_next),
      .i_run    (mac_run),
      .o_last   (mac_last),
      .o_result (result)
   );

endmodule

// File: tb/tb_fir_filter_top.sv
// tb/tb_fir_filter_top.sv - randomized self-checking bench for the bit-serial FIR filter
module tb_fir_filter_top;

   localparam int DW = 24;
   localparam int FD = 32;
   localparam logic [FD*DW-1:0] SAT_COEFS = {FD{24'h7FFFFF}};

   logic tb_clk;
   logic rst_n;
   logic en;
   logic din;
   logic din_valid;
   logic ds_ready;
   logic dut_ready, dut_dout, dut_dout_valid;
   logic sat_ready, sat_dout, sat_dout_valid;

   int total;
   int bad;

   logic signed [DW-1:0] hist [FD];

   fir_filter_top dut (
      .i_clk        (tb_clk),
      .i_rst        (rst_n),
      .i_en         (en),
      .i_din        (din),
      .i_din_valid  (din_valid),
      .i_ready      (ds_ready),
      .o_ready      (dut_ready),
      .o_dout       (dut_dout),
      .o_dout_valid (dut_dout_valid)
   );

   // Second instance with every coefficient near 1.0, so the tap sum far exceeds unity gain
   fir_filter_top #(.DATA_WIDTH(DW), .FIR_DEPTH(FD), .COEFS(SAT_COEFS)) dut_sat (
      .i_clk        (tb_clk),
      .i_rst        (rst_n),
      .i_en         (en),
      .i_din        (din),
      .i_din_valid  (din_valid),
      .i_ready      (ds_ready),
      .o_ready      (sat_ready),
      .o_dout       (sat_dout),
      .o_dout_valid (sat_dout_valid)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   // Reference taps: triangle 1..16..1 times 30000 for the normal filter, 0x7FFFFF for the boosted one
   function automatic longint ref_coef(input bit boosted, input int k);
      if (boosted) return 64'sd8388607;
      return 64'sd30000 * longint'(((k + 1) < (FD - k)) ? (k + 1) : (FD - k));
   endfunction

   function automatic logic [DW-1:0] model_out(input bit boosted);
      longint acc;
      longint q;
      acc = 0;
      for (int k = 0; k < FD; k++) acc += longint'(hist[k]) * ref_coef(boosted, k);
      q = acc >>> (DW - 1);
      if (q > 64'sd8388607) q = 64'sd8388607;
      if (q < -64'sd8388608) q = -64'sd8388608;
      return q[DW-1:0];
   endfunction

   task automatic model_push(input logic [DW-1:0] w);
      for (int k = FD - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = w;
   endtask

   task automatic model_reset();
      for (int k = 0; k < FD; k++) hist[k] = '0;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Serialize one word LSB first with random idle gaps; optional 10-cycle enable drop before bit rx_fz
   task automatic send_word(input logic [DW-1:0] w, input int rx_fz);
      int i;
      int guard;
      bit froze;
      i = 0;
      guard = 0;
      froze = 0;
      while (i < DW && guard < 2000) begin
         guard++;
         if (i == rx_fz && !froze) begin
            froze = 1;
            en = 0;
            din_valid = 1;
            din = w[i];
            repeat (10) begin
               @(negedge tb_clk);
               check("rx_freeze_ready", DW'(dut_ready), DW'(1));
               check("rx_freeze_valid", DW'(dut_dout_valid), '0);
            end
            en = 1;
         end
         if ($urandom_range(0, 3) == 0) begin
            din_valid = 0;
            din = 1'($urandom);
         end else begin
            din_valid = 1;
            din = w[i];
            if (dut_ready) i++;
         end
         @(negedge tb_clk);
      end
      din_valid = 0;
      if (i < DW) check("rx_timeout", DW'(i), DW'(DW));
   endtask

   // Wait out MAC, collect DW output bits, then complete the handshake (ack_mode 1: pulse in TX)
   task automatic recv_word(input int ack_mode, input int tx_fz,
                            output logic [DW-1:0] gm, output logic [DW-1:0] gs);
      int lat;
      int hold;
      lat = 0;
      gm = '0;
      gs = '0;
      check("mac_ready", DW'(dut_ready), '0);
      while (!dut_dout_valid && lat < 200) begin
         din_valid = 1'($urandom);
         din = 1'($urandom);
         @(negedge tb_clk);
         lat++;
      end
      check("mac_latency", DW'(lat), DW'(FD));
      for (int b = 0; b < DW; b++) begin
         check("tx_valid", DW'(dut_dout_valid), DW'(1));
         check("tx_ready", DW'(dut_ready), '0);
         gm[b] = dut_dout;
         gs[b] = sat_dout;
         ds_ready = (ack_mode == 1 && b == 7);
         din_valid = 1'($urandom);
         if (b == tx_fz) begin
            en = 0;
            repeat (10) begin
               @(negedge tb_clk);
               check("tx_freeze_dout", DW'(dut_dout), DW'(gm[b]));
               check("tx_freeze_valid", DW'(dut_dout_valid), DW'(1));
            end
            en = 1;
         end
         @(negedge tb_clk);
      end
      din_valid = 0;
      ds_ready = 0;
      if (ack_mode == 1) begin
         check("acked_ready", DW'(dut_ready), DW'(1));
         check("acked_valid", DW'(dut_dout_valid), '0);
      end else begin
         hold = $urandom_range(1, 4);
         for (int h = 0; h < hold; h++) begin
            check("ack_wait_ready", DW'(dut_ready), '0);
            check("ack_wait_valid", DW'(dut_dout_valid), '0);
            check("ack_wait_dout", DW'(dut_dout), '0);
            @(negedge tb_clk);
         end
         ds_ready = 1;
         @(negedge tb_clk);
         ds_ready = 0;
         check("ack_release_ready", DW'(dut_ready), DW'(1));
      end
   endtask

   task automatic do_word(input logic [DW-1:0] w, input int ack_mode, input int rx_fz, input int tx_fz,
                          input string tag, output logic [DW-1:0] gm, output logic [DW-1:0] gs);
      send_word(w, rx_fz);
      model_push(w);
      recv_word(ack_mode, tx_fz, gm, gs);
      check({tag, "_main"}, gm, model_out(0));
      check({tag, "_boost"}, gs, model_out(1));
   endtask

   task automatic pulse_reset();
      rst_n = 0;
      @(negedge tb_clk);
      @(negedge tb_clk);
      rst_n = 1;
      model_reset();
      @(negedge tb_clk);
   endtask

   task automatic impulse_run(input string tag);
      logic [DW-1:0] gm, gs, w;
      for (int n = 0; n < FD + 2; n++) begin
         w = (n == 0) ? 24'h400000 : 24'h000000;
         do_word(w, int'($urandom_range(0, 1)), -1, -1, tag, gm, gs);
         check({tag, "_tap"}, gm, (n < FD) ? DW'(ref_coef(0, n) >>> 1) : '0);
      end
   endtask

   // Global bound in case the design stops responding altogether
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] gm, gs;
      longint dc_sum;
      total = 0;
      bad = 0;
      rst_n = 0;
      en = 1;
      din = 0;
      din_valid = 0;
      ds_ready = 0;
      model_reset();

      repeat (3) @(negedge tb_clk);
      check("reset_ready", DW'(dut_ready), DW'(1));
      check("reset_dout", DW'(dut_dout), '0);
      check("reset_valid", DW'(dut_dout_valid), '0);
      check("reset_boost_ready", DW'(sat_ready), DW'(1));
      rst_n = 1;
      @(negedge tb_clk);

      impulse_run("impulse");

      dc_sum = 0;
      for (int k = 0; k < FD; k++) dc_sum += ref_coef(0, k);
      for (int n = 0; n < 40; n++) begin
         do_word(24'h400000, int'($urandom_range(0, 1)), -1, -1, "dc", gm, gs);
         if (n >= FD - 1) check("dc_const", gm, DW'((dc_sum * 64'sd4194304) >>> 23));
      end

      for (int n = 0; n < 6; n++) begin
         do_word(DW'($urandom), int'($urandom_range(0, 1)), -1, -1, "rand", gm, gs);
      end
      do_word(DW'($urandom), 0, 10, 13, "freeze", gm, gs);
      do_word(DW'($urandom), 1, 3, 20, "freeze2", gm, gs);

      pulse_reset();
      do_word(24'h7FFFFF, 1, -1, -1, "sat_pos1", gm, gs);
      do_word(24'h7FFFFF, 0, -1, -1, "sat_pos2", gm, gs);
      check("sat_pos", gs, 24'h7FFFFF);
      pulse_reset();
      do_word(24'h800000, 1, -1, -1, "sat_neg1", gm, gs);
      do_word(24'h800000, 0, -1, -1, "sat_neg2", gm, gs);
      check("sat_neg", gs, 24'h800000);

      send_word(DW'($urandom) | 24'h000001, -1);
      repeat (10) @(negedge tb_clk);
      rst_n = 0;
      #1;
      check("midmac_rst_ready", DW'(dut_ready), DW'(1));
      check("midmac_rst_valid", DW'(dut_dout_valid), '0);
      check("midmac_rst_boost_valid", DW'(sat_dout_valid), '0);
      @(negedge tb_clk);
      rst_n = 1;
      model_reset();
      @(negedge tb_clk);
      impulse_run("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_filter_top.md
FIR_FILTER_TOP -- requirements
Module: fir_filter_top

Interface
REQ-001 Parameter DATA_WIDTH, default 24: width of input samples, output samples and coefficients.
REQ-002 Parameter FIR_DEPTH, default 32: number of filter taps.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset; asynchronous, active-low.
REQ-005 i_en  in  1  clock enable; when low, all state (FSM, counters, registers, outputs) holds.
REQ-006 i_din  in  1  serial sample bit, LSB first.
REQ-007 i_din_valid  in  1  i_din carries a valid bit this cycle.
REQ-008 i_ready  in  1  downstream acknowledge of the current output word.
REQ-009 o_ready  out  1  DUT accepts input bits this cycle.
REQ-010 o_dout  out  1  serial filtered sample bit, LSB first.
REQ-011 o_dout_valid  out  1  o_dout carries a valid bit this cycle.

Function
REQ-012 FSM states: IDLE, RX, MAC, TX, ACK; all transitions only on cycles with i_en=1.
REQ-013 o_ready=1 in IDLE and RX only; an input bit is accepted on a rising edge with i_en & o_ready & i_din_valid.
REQ-014 IDLE: first accepted bit is stored as bit 0 and the FSM moves to RX; RX accepts bits 1..DATA_WIDTH-1; RX cycles with i_din_valid=0 hold without advancing.
REQ-015 After bit DATA_WIDTH-1: word enters delay line position 0, older samples shift by one, oldest is dropped; FSM moves to MAC.
REQ-016 Delay line: FIR_DEPTH signed DATA_WIDTH-bit entries, zero after reset.
REQ-017 MAC: one multiply-accumulate per cycle, acc += x[k]*c[k] for k=0..FIR_DEPTH-1, exactly FIR_DEPTH cycles; x[0] is the newest sample.
REQ-018 Samples and coefficients are signed two's complement; coefficients are Q1.(DATA_WIDTH-1).
REQ-019 Accumulator width 2*DATA_WIDTH+clog2(FIR_DEPTH) bits, cleared at MAC entry.
REQ-020 Result = acc arithmetically shifted right by DATA_WIDTH-1 (floor), saturated to the signed DATA_WIDTH-bit range (0x7FFFFF / 0x800000 at default width).
REQ-021 TX: DATA_WIDTH consecutive cycles, o_dout_valid=1, o_dout = result bit 0 first through bit DATA_WIDTH-1; not stallable by i_ready.
REQ-022 Any cycle with i_ready=1 while in TX sets an ack flag; after the last TX bit: ack set -> IDLE, else -> ACK.
REQ-023 ACK: o_dout_valid=0, o_dout=0; i_ready=1 -> IDLE.
REQ-024 Outside TX, o_dout_valid=0 and o_dout=0.
REQ-025 i_din_valid outside IDLE/RX is ignored; no input is lost or buffered.
REQ-026 Minimum word period: DATA_WIDTH + FIR_DEPTH + DATA_WIDTH cycles plus handshake.

Reset
REQ-027 i_rst low: FSM=IDLE, bit counter, tap counter, accumulator, ack flag, delay line and result all cleared, immediately (asynchronously).
REQ-028 Reset outputs: o_ready=1, o_dout=0, o_dout_valid=0.
REQ-029 Reset mid-RX/MAC/TX abandons the word; the partial sample never enters the delay line.

Structure
REQ-030 Package fir_pkg: DATA_WIDTH/FIR_DEPTH defaults, ACC_WIDTH, FSM state enum, constant coefficient array (symmetric low-pass, coefficient sum <= 1.0).
REQ-031 One sub-module fir_mac_core: delay line, tap counter, accumulator, shift/saturate; top holds FSM, deserializer, serializer.

Verification
REQ-032 Impulse: 0x400000 then 31+ zeros -> output word k = c[k] >>> 1 (floor), then 0.
REQ-033 DC: constant 0x400000 for 40 words -> outputs from word 31 onward equal floor(sum(c)*0x400000 / 2^23), constant.
REQ-034 Saturation: force coefficient sum >1 (bench override) with 0x7FFFFF input -> output 0x7FFFFF; 0x800000 input -> 0x800000.
REQ-035 Handshake: i_ready pulsed during TX -> IDLE, o_ready=1 next cycle; i_ready withheld -> ACK held, o_ready=0, until i_ready=1.
REQ-036 i_en=0 for 10 cycles mid-RX and mid-TX -> outputs and bit position frozen; result identical to the uninterrupted run.
REQ-037 Reset asserted mid-MAC -> o_ready=1, o_dout_valid=0 immediately; subsequent impulse reproduces REQ-032 exactly.
